// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared Viterbi decoder parameters, traceback FSM states and trellis helper functions
package viterbi_pkg;
  localparam int K = 5;
  localparam int M = K - 1;
  localparam int S = 1 << M;
  localparam int D = 10;
  localparam int TB_LEN = D - 1;
  localparam int SW = $clog2(S);
  localparam int TW = $clog2(D);
  localparam int CW = $clog2(TB_LEN + 1);
  localparam int FW = $clog2(TB_LEN + 2);
  typedef enum logic [1:0] {IDLE, WALK, EMIT} tb_state_e;
  function automatic logic [M-1:0] pred_state(input logic [M-1:0] s, input logic b);
    return {s[M-2:0], b};
  endfunction
  function automatic logic [TW-1:0] dec_mod_d(input logic [TW-1:0] t);
    return (t == TW'(0)) ? TW'(D - 1) : t - TW'(1);
  endfunction
endpackage

// File: rtl/traceback_unit.sv
// traceback_unit: walks TB_LEN survivor rows back from best_state per trellis step and emits one decoded bit
module traceback_unit
  import viterbi_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [TW-1:0] wr_ptr,
  input  logic [M-1:0]  best_state,
  output logic [SW-1:0] rd_state,
  output logic [TW-1:0] rd_time,
  input  logic          surv_bit,
  output logic          out_bit,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);
  tb_state_e     r_state, w_state;
  logic [SW-1:0] r_rd_state, w_rd_state;
  logic [TW-1:0] r_rd_time, w_rd_time;
  logic [CW-1:0] r_step, w_step;
  logic [FW-1:0] r_fill, w_fill;
  logic          r_out_bit, w_out_bit, r_out_valid, w_out_valid, r_overrun, w_overrun;
  always_comb begin
    w_state = r_state;
    w_rd_state = r_rd_state;
    w_rd_time = r_rd_time;
    w_step = r_step;
    w_fill = r_fill;
    w_out_bit = r_out_bit;
    w_out_valid = 1'b0;
    w_overrun = r_overrun | (start && r_state != IDLE);
    if (r_state == IDLE && start) begin
      w_rd_time = dec_mod_d(wr_ptr);
      w_rd_state = best_state;
      w_step = '0;
      w_fill = (r_fill == FW'(TB_LEN + 1)) ? r_fill : r_fill + FW'(1);
      w_state = WALK;
    end
    if (r_state == WALK) begin
      w_rd_state = pred_state(r_rd_state, surv_bit);
      w_rd_time = dec_mod_d(r_rd_time);
      w_step = r_step + CW'(1);
      w_state = (r_step == CW'(TB_LEN - 1)) ? EMIT : WALK;
    end
    if (r_state == EMIT) begin
      w_out_bit = r_rd_state[SW-1];
      // warm-up: suppress output until the memory holds a full traceback window
      w_out_valid = (r_fill == FW'(TB_LEN + 1));
      w_state = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rd_state <= '0;
      r_rd_time <= '0;
      r_step <= '0;
      r_fill <= '0;
      r_out_bit <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state;
      r_rd_state <= w_rd_state;
      r_rd_time <= w_rd_time;
      r_step <= w_step;
      r_fill <= w_fill;
      r_out_bit <= w_out_bit;
      r_out_valid <= w_out_valid;
      r_overrun <= w_overrun;
    end
  end
  assign rd_state = r_rd_state;
  assign rd_time = r_rd_time;
  assign out_bit = r_out_bit;
  assign out_valid = r_out_valid;
  assign busy = (r_state != IDLE);
  assign overrun = r_overrun;
endmodule

// File: tb/tb_traceback_unit.sv
// tb_traceback_unit: randomized self-checking bench for traceback_unit against a survivor memory model
module tb_traceback_unit;
  import viterbi_pkg::*;
  logic clk = 0, rst = 1, start = 0;
  logic [TW-1:0] wr_ptr = '0, rd_time;
  logic [M-1:0] best_state = '0;
  logic [SW-1:0] rd_state;
  logic surv_bit, out_bit, out_valid, busy, overrun;
  bit mem [D][S];
  int n_checks = 0, n_fail = 0, fill_m = 0;
  bit ovr_m = 0;
  always #5 clk = ~clk;
  assign surv_bit = mem[rd_time][rd_state];
  traceback_unit dut (
    .clk(clk), .rst(rst), .start(start), .wr_ptr(wr_ptr), .best_state(best_state),
    .rd_state(rd_state), .rd_time(rd_time), .surv_bit(surv_bit), .out_bit(out_bit),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_mem(input int mode);
    for (int t = 0; t < D; t++)
      for (int s = 0; s < S; s++)
        mem[t][s] = (mode == 2) ? bit'($urandom_range(1)) : bit'(mode);
  endtask
  task automatic quiet(input int cycles, input string tag);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      seen += int'(out_valid);
      tick();
    end
    check(tag, seen, 0);
  endtask
  task automatic run(input int wr, input int best, input int ovr_at);
    int t, s;
    bit exp_v;
    start = 1;
    wr_ptr = TW'(wr);
    best_state = M'(best);
    tick();
    start = 0;
    fill_m = (fill_m < TB_LEN + 1) ? fill_m + 1 : fill_m;
    exp_v = (fill_m == TB_LEN + 1);
    t = (wr + D - 1) % D;
    s = best;
    for (int k = 0; k < TB_LEN; k++) begin
      check("rd_time", rd_time, t);
      check("rd_state", rd_state, s);
      check("walk_busy", busy, 1);
      if (k == ovr_at) begin
        start = 1;
        wr_ptr = TW'((wr + 5) % D);
        best_state = M'(~best);
      end
      s = (s * 2 + int'(mem[t][s])) % S;
      t = (t + D - 1) % D;
      tick();
      if (k == ovr_at) ovr_m = 1;
      start = 0;
    end
    check("emit_busy", busy, 1);
    check("early_valid", out_valid, 0);
    tick();
    check("out_valid", out_valid, int'(exp_v));
    if (exp_v) check("out_bit", out_bit, s / (S / 2));
    check("idle_busy", busy, 0);
    check("overrun", overrun, int'(ovr_m));
    tick();
    check("strobe_len", out_valid, 0);
  endtask
  initial begin
    tick();
    tick();
    check("rst_rd_state", rd_state, 0);
    check("rst_rd_time", rd_time, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 0;
    for (int i = 0; i < TB_LEN + 1; i++) begin
      fill_mem(2);
      run($urandom_range(D - 1), $urandom_range(S - 1), -1);
    end
    fill_mem(0);
    run(3, 8, -1);
    fill_mem(1);
    run(0, 0, -1);
    for (int i = 0; i < 6; i++) begin
      fill_mem(2);
      run($urandom_range(D - 1), $urandom_range(S - 1), -1);
    end
    fill_mem(2);
    run($urandom_range(D - 1), $urandom_range(S - 1), 4);
    quiet(14, "second_emit");
    check("overrun_sticky", overrun, 1);
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    fill_m = 0;
    ovr_m = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rd_state", rd_state, 0);
    check("mid_rst_rd_time", rd_time, 0);
    check("mid_rst_overrun", overrun, 0);
    quiet(12, "mid_rst_emit");
    fill_mem(2);
    run($urandom_range(D - 1), $urandom_range(S - 1), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/traceback_unit.md
Name: traceback_unit

Overview:
- Read side of the Viterbi survivor memory. Once per trellis step it walks back TB_LEN survivor rows from the current best state and emits one decoded bit.
- Drives the memory's rd_state/rd_time read port and samples the combinational surv_bit in the same cycle.
- Takes best_state from the ACS/path-metric stage and wr_ptr from the survivor memory.

Parameters:
- K, 5, constraint length
- M, K-1, state register width
- S, 1<<M, number of trellis states
- D, 10, survivor memory depth in rows
- TB_LEN, D-1, traceback steps per decode; legal range 1..D-1

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  pulse: a new survivor row was written this cycle
- wr_ptr  input  $clog2(D)  survivor memory write pointer, already advanced past the newest row
- best_state  input  M  state with the best path metric for the newest row
- rd_state  output  $clog2(S)  survivor memory read state
- rd_time  output  $clog2(D)  survivor memory read row
- surv_bit  input  1  survivor bit at mem[rd_time][rd_state], combinational, same cycle
- out_bit  output  1  decoded bit
- out_valid  output  1  one-cycle strobe qualifying out_bit
- busy  output  1  traceback in progress
- overrun  output  1  sticky: a start was dropped

Behaviour:
- Trellis convention:
  - next = {in, s[M-1:1]}.
  - Predecessor of s with survivor bit b is {s[M-2:0], b}.
  - Decoded input bit of a state is s[M-1].
- Reset (rst wins over every other input): rd_state=0, rd_time=0, out_bit=0, out_valid=0, busy=0, overrun=0, fill=0, FSM=IDLE.
- FSM states: IDLE, WALK, EMIT.
- IDLE, start=1:
  - rd_time <= (wr_ptr==0) ? D-1 : wr_ptr-1.
  - rd_state <= best_state.
  - step_cnt <= 0; busy <= 1; go to WALK.
  - fill saturates at TB_LEN+1.
- WALK, each cycle:
  - rd_state <= {rd_state[M-2:0], surv_bit}.
  - rd_time <= (rd_time==0) ? D-1 : rd_time-1.
  - step_cnt++.
  - After TB_LEN reads, go to EMIT.
  - Rows read: t, t-1, ... t-TB_LEN+1 (mod D).
- EMIT (1 cycle):
  - out_bit <= rd_state[M-1].
  - out_valid <= 1 only if fill == TB_LEN+1; otherwise out_valid stays 0 (warm-up).
  - busy <= 0; return to IDLE.
- Latency: start accepted at cycle 0 -> out_valid high at cycle TB_LEN+1, for exactly one cycle.
- start while busy: ignored, fill unchanged, overrun <= 1 (sticky until rst). The running traceback is unaffected.
- Required start spacing: at least TB_LEN+2 cycles.
- TB_LEN <= D-1 guarantees that the one row written during a traceback (slot t+1 mod D) is never read by that traceback.
- rd_state/rd_time hold their last values in IDLE.
- Widths: the mod-D decrement uses an explicit wrap compare, never natural overflow, because D need not be a power of two.

Decomposition:
- viterbi_pkg holds K, M, S, D, TB_LEN defaults, a pred_state(s, b) function, and a dec_mod_d(t) function shared with survivor_mem.
- No sub-module; FSM and counters are one block.

Test Plan (K=5, D=10, TB_LEN=9; behavioural survivor memory model):
- Reset: assert rst 2 cycles -> all outputs 0, busy 0, overrun 0.
- Zero memory, fill primed, wr_ptr=3, best_state=8, start:
  - rd_time sequence 2,1,0,9,8,7,6,5,4.
  - rd_state sequence 8,0,0,...
  - out_valid at cycle 10 with out_bit=0.
- All-ones memory, best_state=0, wr_ptr=0, start:
  - rd_state sequence 0,1,3,7,15,15,...
  - rd_time starts at 9.
  - out_bit=1, out_valid at cycle 10.
- Warm-up: 10 starts spaced 12 cycles apart after reset -> starts 1-9 give no out_valid; start 10 gives exactly one out_valid.
- Overrun: start again 4 cycles into a walk -> overrun=1 and stays 1; the first traceback still emits at cycle 10; no second emit.
- rst at WALK cycle 4 -> next cycle IDLE, busy=0, out_valid never asserted, fill=0.
